uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx.sv | 110 +++++++++++
 tb/tb_uart_tx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Transmit-side request/serial bundle between a word producer and uart_tx.
interface uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_type;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output P_DATA, data_valid, par_en, par_type,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, data_valid, par_en, par_type,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one bit per clk, frame = start, DATA_WIDTH bits LSB first,
// optional parity, stop. Accepts a new word in IDLE or during STOP.
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  accept;

    // State and frame registers; outputs are registered copies of next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // Next state, frame capture and next output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        accept    = 1'b0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.data_valid) accept = 1'b1;
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d   = CNT_W'(cnt_q + 1'b1);
                    shift_d = shift_q >> 1;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                if (bus.data_valid) accept = 1'b1;
                else                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Everything the frame needs is frozen here; later input changes are invisible.
        if (accept) begin
            state_d   = START;
            shift_d   = bus.P_DATA;
            par_en_d  = bus.par_en;
            par_bit_d = (^bus.P_DATA) ^ bus.par_type;
        end

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.TX_OUT = tx_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: fixed frame table, corner sequences, and randomized frames
// checked against a bit-list model of the UART frame.
module tb_uart_tx;
    localparam int unsigned DW = 8;

    logic TX_CLK_TB = 1'b0;
    logic rst;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .clk (TX_CLK_TB),
        .rst (rst),
        .bus (bus)
    );

    always #5 TX_CLK_TB = ~TX_CLK_TB;

    typedef struct {
        logic [DW-1:0] data;
        bit            pe;
        bit            pt;
        logic [10:0]   frame;   // first transmitted bit at index len-1
        int            len;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge TX_CLK_TB);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_tx"},   32'(bus.TX_OUT), 32'd1);
        check({nm, "_busy"}, 32'(bus.busy),   32'd0);
    endtask

    task automatic send(input logic [DW-1:0] d, input bit pe, input bit pt);
        bus.P_DATA     = d;
        bus.par_en     = pe;
        bus.par_type   = pt;
        bus.data_valid = 1'b1;
        step();
        bus.data_valid = 1'b0;
    endtask

    // Checks len frame cycles; at cycle poke_k drives poke data, and drops data_valid one cycle later
    // unless the poke lands on the stop cycle.
    task automatic check_frame(input logic [10:0] frame, input int len, input string nm,
                               input int poke_k, input logic [DW-1:0] poke_d,
                               input bit poke_pt, input bit poke_dv);
        for (int k = 0; k < len; k++) begin
            check($sformatf("%s_bit%0d", nm, k), 32'(bus.TX_OUT), 32'(frame[len-1-k]));
            check($sformatf("%s_busy%0d", nm, k), 32'(bus.busy), 32'd1);
            if (k == poke_k) begin
                bus.P_DATA     = poke_d;
                bus.par_type   = poke_pt;
                bus.data_valid = poke_dv;
            end else if (k == poke_k + 1) begin
                bus.data_valid = 1'b0;
            end
            step();
        end
    endtask

    // Reference frame: list of line levels in transmit order.
    function automatic logic [15:0] model_bits(input logic [DW-1:0] d, input bit pe, input bit pt);
        logic [15:0] b;
        int          n;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < int'(DW); i++) b[1+i] = d[i];
        n = 1 + int'(DW);
        if (pe) begin
            b[n] = 1'(($countones(d) % 2) != 0) ^ pt;
            n++;
        end
        b[n] = 1'b1;
        return b;
    endfunction

    function automatic int model_len(input bit pe);
        return 2 + int'(DW) + (pe ? 1 : 0);
    endfunction

    initial begin
        logic [DW-1:0] d, nd;
        bit            pe, pt, npe, npt, pending;
        logic [15:0]   mb;
        int            ml;

        tbl[0] = '{8'hBB, 1'b1, 1'b0, 11'b01101110101, 11};
        tbl[1] = '{8'hBB, 1'b1, 1'b1, 11'b01101110111, 11};
        tbl[2] = '{8'hBB, 1'b0, 1'b0, 11'b00110111011, 10};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 11'b00000000011, 11};
        tbl[4] = '{8'h01, 1'b1, 1'b0, 11'b01000000011, 11};
        tbl[5] = '{8'hA5, 1'b1, 1'b0, 11'b01010010101, 11};

        // Reset dominates a pending request.
        rst            = 1'b1;
        bus.P_DATA     = 8'hFF;
        bus.data_valid = 1'b1;
        bus.par_en     = 1'b0;
        bus.par_type   = 1'b0;
        step();
        check_idle("rst_c0");
        step();
        check_idle("rst_c1");
        rst            = 1'b0;
        bus.data_valid = 1'b0;
        step();
        check_idle("rst_release0");
        step();
        check_idle("rst_release1");

        for (int v = 0; v < 6; v++) begin
            send(tbl[v].data, tbl[v].pe, tbl[v].pt);
            check_frame(tbl[v].frame, tbl[v].len, $sformatf("tbl%0d", v), -1, '0, 1'b0, 1'b0);
            check_idle($sformatf("tbl%0d_after", v));
            step();
        end

        // Held data_valid: 0xA5 then 0x01 presented on the stop cycle, no gap.
        bus.P_DATA     = 8'hA5;
        bus.par_en     = 1'b1;
        bus.par_type   = 1'b0;
        bus.data_valid = 1'b1;
        step();
        check_frame(tbl[5].frame, 11, "b2b_a", 10, 8'h01, 1'b0, 1'b1);
        bus.data_valid = 1'b0;
        check_frame(tbl[4].frame, 11, "b2b_b", -1, '0, 1'b0, 1'b0);
        check_idle("b2b_after");
        step();

        // Mid-frame input changes and a stray request are ignored.
        send(8'hBB, 1'b1, 1'b0);
        check_frame(tbl[0].frame, 11, "midchg", 3, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check_idle($sformatf("midchg_after%0d", k));
            step();
        end

        // Reset during data bit 3 aborts immediately.
        send(8'hBB, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("abort_bit%0d", k), 32'(bus.TX_OUT), 32'(tbl[0].frame[10-k]));
            if (k == 4) rst = 1'b1;
            step();
        end
        check_idle("abort_rst");
        rst = 1'b0;
        step();
        check_idle("abort_post");

        // Randomized frames with garbage on inputs mid-frame and random back-to-back chaining.
        pending = 1'b0;
        d = '0; pe = 1'b0; pt = 1'b0;
        for (int f = 0; f < 60; f++) begin
            if (!pending) begin
                for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                    check_idle($sformatf("rnd%0d_gap", f));
                    step();
                end
                d  = DW'($urandom);
                pe = 1'($urandom);
                pt = 1'($urandom);
                send(d, pe, pt);
            end
            mb = model_bits(d, pe, pt);
            ml = model_len(pe);
            pending = 1'b0;
            for (int k = 0; k < ml; k++) begin
                check($sformatf("rnd%0d_bit%0d", f, k), 32'(bus.TX_OUT), 32'(mb[k]));
                check($sformatf("rnd%0d_busy%0d", f, k), 32'(bus.busy), 32'd1);
                if (k < ml - 1) begin
                    bus.P_DATA     = DW'($urandom);
                    bus.par_en     = 1'($urandom);
                    bus.par_type   = 1'($urandom);
                    bus.data_valid = 1'($urandom);
                end else if (f < 59 && $urandom_range(1, 0) == 1) begin
                    nd  = DW'($urandom);
                    npe = 1'($urandom);
                    npt = 1'($urandom);
                    bus.P_DATA     = nd;
                    bus.par_en     = npe;
                    bus.par_type   = npt;
                    bus.data_valid = 1'b1;
                    pending        = 1'b1;
                end else begin
                    bus.data_valid = 1'b0;
                end
                step();
            end
            bus.data_valid = 1'b0;
            if (pending) begin
                d  = nd;
                pe = npe;
                pt = npt;
            end else begin
                check_idle($sformatf("rnd%0d_end", f));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
